// File: rtl/range_stream_driver.sv
// Buffers a host burst and replays it on the range-finder go/data/finish stream,
// capturing the reported range. Define RANGE_STREAM_CHECK_EN to build the min/max range check.
module range_stream_driver #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             wr_valid_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic             wr_ready_o,
   input  logic             start_i,
   output logic             go_o,
   output logic [WIDTH-1:0] data_out_o,
   output logic             finish_o,
   input  logic [WIDTH-1:0] range_in_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] range_out_o,
   output logic             underrun_o,
   output logic             mismatch_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DepthC = CW'(DEPTH);
   localparam logic [CW-1:0] OneC   = CW'(1);
   localparam logic [CW-1:0] TwoC   = CW'(2);

   typedef enum logic [1:0] {IDLE, FIRST, STREAM, LAST} state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d, count_eff;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] pop_data;
   logic             wr_en, pop;

   logic             go_q, go_d, finish_q, finish_d, busy_q, busy_d;
   logic             done_q, done_d, underrun_q, underrun_d, wr_ready_q, wr_ready_d;
   logic [WIDTH-1:0] data_q, data_d, range_q, range_d;

   assign wr_en     = wr_valid_i & wr_ready_q;
   assign count_eff = count_q + CW'(wr_en);
   assign pop_data  = mem_q[rd_ptr_q];

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         go_q       <= 1'b0;
         finish_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
         wr_ready_q <= 1'b1;
         data_q     <= '0;
         range_q    <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
         rd_ptr_q   <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
         count_q    <= count_d;
         go_q       <= go_d;
         finish_q   <= finish_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
         wr_ready_q <= wr_ready_d;
         data_q     <= data_d;
         range_q    <= range_d;
      end
   end

   always_ff @(posedge clock_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
   end

   // count_q already excludes sample 0 once in FIRST, so it is the number still to send.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:          if (start_i && (count_eff >= TwoC)) state_d = FIRST;
         FIRST, STREAM: state_d = (count_q > OneC) ? STREAM : LAST;
         LAST:          state_d = IDLE;
         default:       state_d = IDLE;
      endcase
   end

   // Outputs are registered: each value is computed for the state being entered.
   always_comb begin
      pop        = (state_d != IDLE);
      go_d       = (state_d == FIRST);
      finish_d   = (state_d == LAST);
      busy_d     = (state_d != IDLE);
      data_d     = pop ? pop_data : data_q;
      done_d     = (state_q == LAST);
      underrun_d = (state_q == IDLE) && start_i && (count_eff < TwoC);
      count_d    = count_eff - CW'(pop);
      wr_ready_d = (state_d == IDLE) && (count_d < DepthC);
      range_d    = (state_q == LAST) ? range_in_i : range_q;
   end

`ifdef RANGE_STREAM_CHECK_EN
   logic [WIDTH-1:0] min_q, min_d, max_q, max_d;
   logic             mismatch_q, mismatch_d;

   // Running min/max seeded by sample 0; complete by LAST since the final pop precedes it.
   always_comb begin
      min_d      = min_q;
      max_d      = max_q;
      mismatch_d = mismatch_q;
      if (state_d == FIRST) begin
         min_d = pop_data;
         max_d = pop_data;
      end else if (pop) begin
         if (pop_data < min_q) min_d = pop_data;
         if (pop_data > max_q) max_d = pop_data;
      end
      if (state_q == LAST) mismatch_d = (range_in_i != (max_q - min_q));
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         min_q      <= '0;
         max_q      <= '0;
         mismatch_q <= 1'b0;
      end else begin
         min_q      <= min_d;
         max_q      <= max_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign mismatch_o = mismatch_q;
`else
   assign mismatch_o = 1'b0;
`endif

   assign wr_ready_o  = wr_ready_q;
   assign go_o        = go_q;
   assign data_out_o  = data_q;
   assign finish_o    = finish_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign range_out_o = range_q;
   assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_range_stream_driver.sv
// Directed bench for range_stream_driver with a small behavioural range-finder receiver.
module tb_range_stream_driver;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       wrValid = 1'b0;
   logic [7:0] wrData = 8'd0;
   logic       wrReady;
   logic       start = 1'b0;
   logic       go, finish, busy, done, underrun, mismatch;
   logic [7:0] dataOut, rangeIn, rangeOut;
   logic       forceZero = 1'b0;

   int compared = 0;
   int mismatched = 0;

   logic [7:0] rxMin = 8'd0, rxMax = 8'd0, curMin, curMax;
   logic [7:0] burstVals [8] = '{8'd7, 8'd0, 8'd6, 8'd1, 8'd5, 8'd2, 8'd4, 8'd3};
   int goCount, finCount;

   range_stream_driver #(.WIDTH(8), .DEPTH(8)) dut (
      .clock_i(clock), .reset_i(reset),
      .wr_valid_i(wrValid), .wr_data_i(wrData), .wr_ready_o(wrReady),
      .start_i(start), .go_o(go), .data_out_o(dataOut), .finish_o(finish),
      .range_in_i(rangeIn), .busy_o(busy), .done_o(done),
      .range_out_o(rangeOut), .underrun_o(underrun), .mismatch_o(mismatch)
   );

   always #5 clock = ~clock;

   // Receiver stand-in: reports max-min of the stream on the finish cycle, junk otherwise.
   always_comb begin
      curMin = go ? dataOut : ((dataOut < rxMin) ? dataOut : rxMin);
      curMax = go ? dataOut : ((dataOut > rxMax) ? dataOut : rxMax);
      if (forceZero)   rangeIn = 8'd0;
      else if (finish) rangeIn = curMax - curMin;
      else             rangeIn = 8'hA5;
   end

   always_ff @(posedge clock) begin
      if (busy) begin
         rxMin <= curMin;
         rxMax <= curMax;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] value);
      wrValid = 1'b1;
      wrData  = value;
      step();
      wrValid = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   initial begin
      // Reset values
      step();
      checkOutput("reset go", 32'(go), 0);
      checkOutput("reset finish", 32'(finish), 0);
      checkOutput("reset data", 32'(dataOut), 0);
      checkOutput("reset busy", 32'(busy), 0);
      checkOutput("reset done", 32'(done), 0);
      checkOutput("reset underrun", 32'(underrun), 0);
      checkOutput("reset mismatch", 32'(mismatch), 0);
      checkOutput("reset rangeOut", 32'(rangeOut), 0);
      checkOutput("reset wrReady", 32'(wrReady), 1);
      reset = 1'b0;
      step();

      // Burst 5,9,3,7
      applyStimulus(8'd5); applyStimulus(8'd9); applyStimulus(8'd3); applyStimulus(8'd7);
      start = 1'b1; step(); start = 1'b0;
      checkOutput("b4 go", 32'(go), 1);
      checkOutput("b4 data0", 32'(dataOut), 5);
      checkOutput("b4 busy", 32'(busy), 1);
      checkOutput("b4 finish0", 32'(finish), 0);
      step();
      checkOutput("b4 go1", 32'(go), 0);
      checkOutput("b4 data1", 32'(dataOut), 9);
      step();
      checkOutput("b4 data2", 32'(dataOut), 3);
      checkOutput("b4 finish2", 32'(finish), 0);
      step();
      checkOutput("b4 finish3", 32'(finish), 1);
      checkOutput("b4 data3", 32'(dataOut), 7);
      checkOutput("b4 done early", 32'(done), 0);
      step();
      checkOutput("b4 done", 32'(done), 1);
      checkOutput("b4 rangeOut", 32'(rangeOut), 6);
      checkOutput("b4 mismatch", 32'(mismatch), 0);
      checkOutput("b4 busy end", 32'(busy), 0);
      checkOutput("b4 finish end", 32'(finish), 0);
      step();
      checkOutput("b4 done pulse", 32'(done), 0);

      // Single sample underrun, then write+start in the same cycle
      applyStimulus(8'd42);
      start = 1'b1; step(); start = 1'b0;
      checkOutput("ur underrun", 32'(underrun), 1);
      checkOutput("ur go", 32'(go), 0);
      checkOutput("ur busy", 32'(busy), 0);
      step();
      checkOutput("ur pulse", 32'(underrun), 0);
      wrValid = 1'b1; wrData = 8'd42; start = 1'b1;
      step();
      wrValid = 1'b0; start = 1'b0;
      checkOutput("b2 go", 32'(go), 1);
      checkOutput("b2 data0", 32'(dataOut), 42);
      checkOutput("b2 underrun", 32'(underrun), 0);
      step();
      checkOutput("b2 finish", 32'(finish), 1);
      checkOutput("b2 go1", 32'(go), 0);
      step();
      checkOutput("b2 done", 32'(done), 1);
      checkOutput("b2 rangeOut", 32'(rangeOut), 0);
      step();

      // Fill to DEPTH, ninth write dropped
      for (int i = 0; i < 8; i++) applyStimulus(burstVals[i]);
      checkOutput("full wrReady", 32'(wrReady), 0);
      applyStimulus(8'd99);
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checkOutput("b8 data", 32'(dataOut), 32'(burstVals[i]));
         checkOutput("b8 finish", 32'(finish), (i == 7) ? 32'd1 : 32'd0);
         step();
      end
      checkOutput("b8 done", 32'(done), 1);
      checkOutput("b8 rangeOut", 32'(rangeOut), 7);
      step();

      // Receiver forced to report 0 for burst 10,250, then an honest rerun
      forceZero = 1'b1;
      applyStimulus(8'd10); applyStimulus(8'd250);
      start = 1'b1; step(); start = 1'b0;
      step(); step();
      checkOutput("force done", 32'(done), 1);
      checkOutput("force rangeOut", 32'(rangeOut), 0);
`ifdef RANGE_STREAM_CHECK_EN
      checkOutput("force mismatch", 32'(mismatch), 1);
`else
      checkOutput("force mismatch", 32'(mismatch), 0);
`endif
      forceZero = 1'b0;
      step();
      applyStimulus(8'd10); applyStimulus(8'd250);
      start = 1'b1; step(); start = 1'b0;
      step(); step();
      checkOutput("rerun done", 32'(done), 1);
      checkOutput("rerun rangeOut", 32'(rangeOut), 240);
      checkOutput("rerun mismatch", 32'(mismatch), 0);
      step();

      // Reset during STREAM of a 6-sample burst
      for (int i = 1; i <= 6; i++) applyStimulus(8'(i));
      start = 1'b1; step(); start = 1'b0;
      step(); step();
      checkOutput("mid busy", 32'(busy), 1);
      reset = 1'b1; step(); reset = 1'b0;
      checkOutput("mid go", 32'(go), 0);
      checkOutput("mid finish", 32'(finish), 0);
      checkOutput("mid busy after", 32'(busy), 0);
      checkOutput("mid done", 32'(done), 0);
      step();
      checkOutput("mid done later", 32'(done), 0);
      start = 1'b1; step(); start = 1'b0;
      checkOutput("mid flushed underrun", 32'(underrun), 1);
      checkOutput("mid flushed go", 32'(go), 0);
      step();

      // start held through a burst, writes attempted while busy
      applyStimulus(8'd20); applyStimulus(8'd30); applyStimulus(8'd10); applyStimulus(8'd40);
      start = 1'b1; step();
      goCount = 0; finCount = 0;
      for (int i = 0; i < 4; i++) begin
         goCount += int'(go);
         finCount += int'(finish);
         if (i == 0) begin
            wrValid = 1'b1; wrData = 8'd77;
         end
         if (i == 1) checkOutput("held wrReady busy", 32'(wrReady), 0);
         step();
      end
      start = 1'b0; wrValid = 1'b0;
      checkOutput("held done", 32'(done), 1);
      checkOutput("held go", 32'(go), 0);
      checkOutput("held go count", 32'(goCount), 1);
      checkOutput("held finish count", 32'(finCount), 1);
      checkOutput("held rangeOut", 32'(rangeOut), 30);
      start = 1'b1; step(); start = 1'b0;
      checkOutput("held dropped underrun", 32'(underrun), 1);
      checkOutput("held dropped go", 32'(go), 0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
